mem_read_arbiter: RTL
=====================

// Module: mem_read_arbiter
// PURPOSE
//  Shares the single Avalon-MM read master (mem_addr / mem_read_enable / wait_request / mem_read_ready)
//  between N_REQ algorithm-side requesters (graph fetch, distance fetch, frontier fetch units of the
//  Dijkstra core). Round-robin grant, one outstanding read at a time, per-requester response routing.
//  Read watchdog converts a lost response into an error response instead of a hang.
// PARAMETERS
//  N_REQ       4     number of requesters (2..8)
//  ADDR_WIDTH  32    byte address width
//  DATA_WIDTH  16    read data width
//  TIMEOUT     1024  max cycles in WAIT_DATA before error response; 0 disables watchdog
// PORTS
//  mem_clock        in   1                  single clock for whole block
//  mem_reset        in   1                  synchronous, active-high reset
//  req_valid        in   N_REQ              per-requester read request, level, held until resp_valid
//  req_addr         in   N_REQ*ADDR_WIDTH   flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  resp_valid       out  N_REQ              one-cycle pulse, response for requester i
//  resp_data        out  DATA_WIDTH         shared response data, valid only with a resp_valid bit
//  resp_error       out  1                  qualifies resp_valid: 1 = watchdog timeout, resp_data = 0
//  grant_id         out  $clog2(N_REQ)      index of requester currently owning the master (debug)
//  mem_addr         out  ADDR_WIDTH         Avalon address
//  mem_read_enable  out  1                  Avalon read
//  wait_request     in   1                  Avalon waitrequest
//  mem_read_ready   in   1                  Avalon readdatavalid
//  mem_read_data    in   DATA_WIDTH         Avalon readdata
//  timeout_flag     out  1                  sticky, set on any watchdog expiry, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant_id=0, resp_valid=0, resp_data=0, resp_error=0,
//   mem_addr=0, mem_read_enable=0, timeout_flag=0, watchdog counter=0. Reset mid-transaction
//   abandons it; no resp_valid is produced for it. All outputs registered, never driven to Z.
//  FSM:
//   IDLE      any req_valid: pick first set bit searching rr_ptr, rr_ptr+1, ... (mod N_REQ);
//             latch grant_id, mem_addr <= its req_addr; mem_read_enable <= 1; -> ISSUE. else stay.
//   ISSUE     hold mem_addr/mem_read_enable stable while wait_request=1. On wait_request=0:
//             mem_read_enable <= 0, clear counter, -> WAIT_DATA.
//   WAIT_DATA mem_read_ready=1: resp_data <= mem_read_data, resp_valid[grant_id] <= 1,
//             resp_error <= 0, -> RESP. Else if TIMEOUT!=0 and counter==TIMEOUT-1: resp_data <= 0,
//             resp_valid[grant_id] <= 1, resp_error <= 1, timeout_flag <= 1, -> RESP. Else counter++.
//   RESP      resp_valid/resp_error cleared next cycle (exactly 1-cycle pulse);
//             rr_ptr <= grant_id+1 (wraps N_REQ-1 -> 0); -> IDLE.
//  Latency: req_valid rising in cycle 0 -> mem_read_enable high in cycle 1 (if IDLE);
//   mem_read_ready in cycle k -> resp_valid in cycle k+1. Min back-to-back period 4 cycles + memory.
//  Requester rule: deassert req_valid the cycle after resp_valid; a still-high req_valid in IDLE is
//   treated as a new request. req_addr must be stable while req_valid=1; sampled only in IDLE.
//  Arbitration fairness: a continuously requesting requester waits at most N_REQ-1 grants.
//  req_valid dropped by a requester after grant does not cancel the read; response still pulses.
//  mem_read_ready in IDLE/ISSUE/RESP (late data after timeout) is ignored.
//  mem_read_ready and watchdog expiry in the same cycle: data wins, resp_error=0.
//  Simultaneous requests from all N_REQ: served in order rr_ptr, rr_ptr+1, ...
// TESTING
//  1 Single req: req_valid=0001, addr0=0x100, wait_request low, data 0xBEEF after 3 cycles ->
//    one mem read at 0x100, resp_valid=0001 pulse 1 cycle, resp_data=0xBEEF, resp_error=0.
//  2 Round robin: req_valid=1111 held (each dropped/reraised after its resp) -> grant order 0,1,2,3,0;
//    then with rr_ptr=2 and req_valid=0011 -> grant 0 before 1.
//  3 Wait-state stall: wait_request=1 for 5 cycles -> mem_addr/mem_read_enable stable all 5 cycles,
//    exactly one accepted read, response routed to correct requester.
//  4 Timeout: TIMEOUT=16, no mem_read_ready -> resp_valid pulse 16 cycles after acceptance with
//    resp_error=1, resp_data=0, timeout_flag=1 sticky; late mem_read_ready in IDLE ignored.
//  5 Reset mid-WAIT_DATA: assert mem_reset one cycle -> all outputs at reset values next edge,
//    no resp_valid for aborted read, next request served normally from rr_ptr=0.
//  6 Same-cycle data + timeout expiry -> resp_error=0, resp_data=mem_read_data.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one Avalon-MM read master between N_REQ requesters.
// Round-robin grant, a single outstanding read, per-requester response strobe,
// and a read watchdog that turns a lost response into an error response.

// Per-requester response strobe. A separate register per lane keeps the
// routing decode local to each requester's output bit.
module mem_read_arbiter_lane #(
   parameter int GW   = 2,
   parameter int LANE = 0
) (
   input  logic          mem_clock,
   input  logic          mem_reset,
   input  logic          fire,
   input  logic [GW-1:0] sel,
   output logic          resp_valid
);

   // one-cycle strobe when the completing read belongs to this lane
   always_ff @(posedge mem_clock) begin
      if (mem_reset) resp_valid <= 1'b0;
      else           resp_valid <= fire && (sel == GW'(LANE));
   end

endmodule

module mem_read_arbiter #(
   parameter int N_REQ      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic                          mem_clock,
   input  logic                          mem_reset,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
   output logic [N_REQ-1:0]              resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          resp_error,
   output logic [$clog2(N_REQ)-1:0]      grant_id,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic                          mem_read_enable,
   input  logic                          wait_request,
   input  logic                          mem_read_ready,
   input  logic [DATA_WIDTH-1:0]         mem_read_data,
   output logic                          timeout_flag
);

   localparam int GW    = $clog2(N_REQ);
   // watchdog counter only needs to reach TIMEOUT-1
   localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} state_t;

   // arbitration result: whether anyone is requesting, and who wins
   typedef struct packed {
      logic          found;
      logic [GW-1:0] id;
   } pick_t;

   state_t                           state;
   logic [GW-1:0]                    rr_ptr;
   logic [CW-1:0]                    wd_cnt;
   logic [N_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
   logic [GW:0]                      pos;
   pick_t                            pick;
   logic                             expire;
   logic                             fire;

   // packed view of the flattened address bus, requester i in row i
   assign addr_v = req_addr;

   // watchdog expiry is only meaningful when the watchdog is enabled
   assign expire = (TIMEOUT != 0) && (wd_cnt == CW'(TLAST));

   // a read completes on data or on expiry; data has priority in the FSM
   assign fire = (state == WAIT_DATA) && (mem_read_ready || expire);

   // round-robin search: walk offsets downward so the smallest offset from
   // rr_ptr is the last (winning) assignment
   always_comb begin
      pick = '0;
      pos  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, rr_ptr} + (GW+1)'(k);
         if (pos >= (GW+1)'(N_REQ)) pos = pos - (GW+1)'(N_REQ);
         if (req_valid[pos[GW-1:0]]) begin
            pick.found = 1'b1;
            pick.id    = pos[GW-1:0];
         end
      end
   end

   // control FSM with registered master-side and response-side outputs
   always_ff @(posedge mem_clock) begin
      if (mem_reset) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         grant_id        <= '0;
         resp_data       <= '0;
         resp_error      <= 1'b0;
         mem_addr        <= '0;
         mem_read_enable <= 1'b0;
         timeout_flag    <= 1'b0;
         wd_cnt          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick.found) begin
                  grant_id        <= pick.id;
                  mem_addr        <= addr_v[pick.id];
                  mem_read_enable <= 1'b1;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               // address and read stay put until the slave stops stalling
               if (!wait_request) begin
                  mem_read_enable <= 1'b0;
                  wd_cnt          <= '0;
                  state           <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (mem_read_ready) begin
                  resp_data  <= mem_read_data;
                  resp_error <= 1'b0;
                  state      <= RESP;
               end else if (expire) begin
                  resp_data    <= '0;
                  resp_error   <= 1'b1;
                  timeout_flag <= 1'b1;
                  state        <= RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            RESP: begin
               // strobe ends here; next search starts just past the winner
               resp_error <= 1'b0;
               rr_ptr     <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      mem_read_arbiter_lane #(
         .GW   (GW),
         .LANE (i)
      ) u_lane (
         .mem_clock  (mem_clock),
         .mem_reset  (mem_reset),
         .fire       (fire),
         .sel        (grant_id),
         .resp_valid (resp_valid[i])
      );
   end

endmodule
